// File: rtl/stepper_seq.sv
// stepper_seq: counted, rate-controlled 4-coil stepper move engine.
// A move is started with a start/done handshake. It runs cmd_steps steps,
// one every cmd_div+1 clocks, in wave, full-step or half-step drive.
// The engine also tracks a signed, wrapping absolute position.
module stepper_seq #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int POS_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [1:0]       cmd_mode,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             hold_en,
    output logic [3:0]       coil,
    output logic             step_pulse,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] pos
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;

    logic             state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       coil_q, coil_d;
    logic             step_pulse_q, step_pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    // Eight-entry half-step phase table; even indices energise one coil,
    // odd indices energise two adjacent coils.
    function automatic logic [3:0] phase_coil(input logic [2:0] idx);
        logic [3:0] c;
        case (idx)
            3'd0:    c = 4'b0001;
            3'd1:    c = 4'b0011;
            3'd2:    c = 4'b0010;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0100;
            3'd5:    c = 4'b1100;
            3'd6:    c = 4'b1000;
            default: c = 4'b1001;
        endcase
        return c;
    endfunction

    // Move engine next-state logic: command acceptance, rate divider, stepping and abort.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pos_d        = pos_q;
        remaining_d  = remaining_q;
        div_cnt_d    = div_cnt_q;
        div_d        = div_q;
        dir_d        = dir_q;
        mode_d       = mode_q;
        aborted_d    = aborted_q;
        step_pulse_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d     = cmd_dir;
                    mode_d    = cmd_mode;
                    div_d     = cmd_div;
                    aborted_d = 1'b0;
                    if (cmd_mode == MODE_FULL) begin
                        idx_d = idx_q | 3'b001;
                    end else if (cmd_mode == MODE_HALF) begin
                        idx_d = idx_q;
                    end else begin
                        idx_d = idx_q & 3'b110;
                    end
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d = cmd_steps;
                        div_cnt_d   = cmd_div;
                        state_d     = ST_RUN;
                    end
                end
            end
            default: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - DIV_W'(1);
                end else begin
                    if (dir_q) begin
                        idx_d = idx_q + ((mode_q == MODE_HALF) ? 3'd1 : 3'd2);
                        pos_d = pos_q + POS_W'(1);
                    end else begin
                        idx_d = idx_q - ((mode_q == MODE_HALF) ? 3'd1 : 3'd2);
                        pos_d = pos_q - POS_W'(1);
                    end
                    remaining_d  = remaining_q - CNT_W'(1);
                    step_pulse_d = 1'b1;
                    div_cnt_d    = div_q;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase

        busy_d = (state_d == ST_RUN);
        coil_d = (busy_d || hold_en) ? phase_coil(idx_d) : 4'b0000;
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            pos_q        <= '0;
            remaining_q  <= '0;
            div_cnt_q    <= '0;
            div_q        <= '0;
            dir_q        <= 1'b0;
            mode_q       <= '0;
            coil_q       <= '0;
            step_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pos_q        <= pos_d;
            remaining_q  <= remaining_d;
            div_cnt_q    <= div_cnt_d;
            div_q        <= div_d;
            dir_q        <= dir_d;
            mode_q       <= mode_d;
            coil_q       <= coil_d;
            step_pulse_q <= step_pulse_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign coil       = coil_q;
    assign step_pulse = step_pulse_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign pos        = pos_q;

endmodule

// File: tb/tb_stepper_seq.sv
// Directed testbench for stepper_seq. It drives a default-width instance and
// a 4-bit-position instance from the same stimulus.
module tb_stepper_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic [1:0]  cmd_mode = 2'b00;
    logic [15:0] cmd_div = '0;
    logic        hold_en = 1'b0;

    logic [3:0]  coil, coil_s;
    logic        step_pulse, step_pulse_s;
    logic        busy, busy_s;
    logic        done, done_s;
    logic        aborted, aborted_s;
    logic [23:0] pos;
    logic [3:0]  pos_s;

    int checks = 0;
    int errors = 0;

    stepper_seq dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_mode(cmd_mode),
        .cmd_div(cmd_div), .hold_en(hold_en), .coil(coil),
        .step_pulse(step_pulse), .busy(busy), .done(done),
        .aborted(aborted), .pos(pos)
    );

    stepper_seq #(.POS_W(4)) dut_small (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_mode(cmd_mode),
        .cmd_div(cmd_div), .hold_en(hold_en), .coil(coil_s),
        .step_pulse(step_pulse_s), .busy(busy_s), .done(done_s),
        .aborted(aborted_s), .pos(pos_s)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present a command and hold start high across exactly one edge.
    task automatic applyStimulus(input logic [15:0] steps, input logic dir,
                                 input logic [1:0] mode, input logic [15:0] div);
        cmd_steps = steps;
        cmd_dir   = dir;
        cmd_mode  = mode;
        cmd_div   = div;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    logic [3:0] exp_ccw [9] = '{4'b1001, 4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                4'b0010, 4'b0011, 4'b0001, 4'b1001};

    initial begin
        hold_en = 1'b1;
        applyReset();
        checkOutput("rst_coil", 32'(coil), 32'h0);
        checkOutput("rst_pos", 32'(pos), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_aborted", 32'(aborted), 32'h0);
        checkOutput("rst_pulse", 32'(step_pulse), 32'h0);

        // Test 1: full-step cw, 3 steps, divider 2.
        applyStimulus(16'd3, 1'b1, 2'b01, 16'd2);
        checkOutput("t1_busy0", 32'(busy), 32'h1);
        checkOutput("t1_coil0", 32'(coil), 32'h3);
        for (int c = 1; c <= 9; c++) begin
            tick();
            checkOutput("t1_pulse", 32'(step_pulse), 32'((c % 3) == 0));
            checkOutput("t1_done", 32'(done), 32'(c == 9));
            if (c == 3) checkOutput("t1_coil3", 32'(coil), 32'h6);
            if (c == 6) checkOutput("t1_coil6", 32'(coil), 32'hC);
        end
        checkOutput("t1_coil9", 32'(coil), 32'h9);
        checkOutput("t1_pos", 32'(pos), 32'h3);
        checkOutput("t1_busy9", 32'(busy), 32'h0);
        tick();
        checkOutput("t1_done_clr", 32'(done), 32'h0);

        // Test 2: half-step ccw from index 0, 9 steps, one per cycle.
        applyReset();
        applyStimulus(16'd9, 1'b0, 2'b10, 16'd0);
        checkOutput("t2_coil0", 32'(coil), 32'h1);
        for (int c = 0; c < 9; c++) begin
            tick();
            checkOutput("t2_pulse", 32'(step_pulse), 32'h1);
            checkOutput("t2_coil", 32'(coil), 32'(exp_ccw[c]));
        end
        checkOutput("t2_pos", 32'(pos), 32'hFFFFF7);
        checkOutput("t2_done", 32'(done), 32'h1);

        // Test 3: half cw 4 steps to reach index 3, then a single wave step.
        applyStimulus(16'd4, 1'b1, 2'b10, 16'd0);
        repeat (4) tick();
        checkOutput("t3_coil_idx3", 32'(coil), 32'h6);
        applyStimulus(16'd1, 1'b1, 2'b00, 16'd0);
        checkOutput("t3_aligned", 32'(coil), 32'h2);
        tick();
        checkOutput("t3_coil", 32'(coil), 32'h4);
        checkOutput("t3_pos", 32'(pos), 32'hFFFFFC);
        checkOutput("t3_done", 32'(done), 32'h1);

        // Test 4: zero-step command completes immediately.
        applyStimulus(16'd0, 1'b1, 2'b10, 16'd5);
        checkOutput("t4_done", 32'(done), 32'h1);
        checkOutput("t4_busy", 32'(busy), 32'h0);
        checkOutput("t4_coil", 32'(coil), 32'h4);
        checkOutput("t4_pos", 32'(pos), 32'hFFFFFC);
        tick();
        checkOutput("t4_done_clr", 32'(done), 32'h0);
        checkOutput("t4_busy2", 32'(busy), 32'h0);

        // Test 5: stop coinciding with the second step of a 5-step move.
        applyStimulus(16'd5, 1'b1, 2'b01, 16'd1);
        checkOutput("t5_coil0", 32'(coil), 32'hC);
        tick();
        tick();
        checkOutput("t5_pulse1", 32'(step_pulse), 32'h1);
        checkOutput("t5_pos1", 32'(pos), 32'hFFFFFD);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("t5_pulse2", 32'(step_pulse), 32'h0);
        checkOutput("t5_done", 32'(done), 32'h1);
        checkOutput("t5_aborted", 32'(aborted), 32'h1);
        checkOutput("t5_busy", 32'(busy), 32'h0);
        checkOutput("t5_pos2", 32'(pos), 32'hFFFFFD);
        checkOutput("t5_coil", 32'(coil), 32'h9);
        applyStimulus(16'd0, 1'b1, 2'b10, 16'd0);
        checkOutput("t5_abort_clr", 32'(aborted), 32'h0);

        // Test 6a: 4-bit position wraps from +7 to -8.
        applyReset();
        applyStimulus(16'd8, 1'b1, 2'b01, 16'd0);
        repeat (7) tick();
        checkOutput("t6_pos7", 32'(pos_s), 32'h7);
        tick();
        checkOutput("t6_pos_wrap", 32'(pos_s), 32'h8);
        checkOutput("t6_done_s", 32'(done_s), 32'h1);

        // Test 6b: asynchronous reset in the middle of a move.
        applyReset();
        applyStimulus(16'd10, 1'b1, 2'b01, 16'd3);
        repeat (5) tick();
        checkOutput("t6_prerst_pos", 32'(pos), 32'h1);
        checkOutput("t6_prerst_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_rst_coil", 32'(coil), 32'h0);
        checkOutput("t6_rst_pos", 32'(pos), 32'h0);
        checkOutput("t6_rst_busy", 32'(busy), 32'h0);
        checkOutput("t6_rst_done", 32'(done), 32'h0);
        #1 rst = 1'b0;
        tick();
        checkOutput("t6_postrst_coil", 32'(coil), 32'h1);

        // Test 6c: start and command changes during a move are ignored.
        applyStimulus(16'd3, 1'b1, 2'b01, 16'd1);
        tick();
        cmd_steps = 16'd9;
        cmd_dir   = 1'b0;
        cmd_div   = 16'd0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        checkOutput("t6c_pulse1", 32'(step_pulse), 32'h1);
        checkOutput("t6c_pos1", 32'(pos), 32'h1);
        for (int c = 3; c <= 6; c++) begin
            tick();
            checkOutput("t6c_pulse", 32'(step_pulse), 32'((c % 2) == 0));
            checkOutput("t6c_done", 32'(done), 32'(c == 6));
        end
        checkOutput("t6c_pos", 32'(pos), 32'h3);
        checkOutput("t6c_coil", 32'(coil), 32'h9);
        checkOutput("t6c_busy", 32'(busy), 32'h0);
        tick();
        checkOutput("t6c_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
